// File: rtl/clk_period_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_period_meter_pkg
// Brief    : Shared state encoding and default sizing for the period meter.
// Revision : 1.0
// ============================================================================
package clk_period_meter_pkg;

   localparam int          DEF_WIDTH   = 26;
   localparam logic [25:0] DEF_TIMEOUT = 26'h3FFFFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      TRACK = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/clk_period_meter_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_period_meter_if
// Brief    : Measured input plus measurement/result outputs of the meter.
// Revision : 1.0
// ============================================================================
interface clk_period_meter_if
   import clk_period_meter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) ();

   logic             sig_in;
   logic [WIDTH-1:0] half_period;
   logic             meas_valid;
   logic             meas_stb;
   logic             locked;
   logic             rise_pulse;
   logic             fall_pulse;
   logic             timeout;

   modport master (
      input  sig_in,
      output half_period, meas_valid, meas_stb, locked,
             rise_pulse, fall_pulse, timeout
   );

   modport slave (
      output sig_in,
      input  half_period, meas_valid, meas_stb, locked,
             rise_pulse, fall_pulse, timeout
   );

endinterface
`default_nettype wire

// File: rtl/clk_period_meter_sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Brief    : 3-flop synchronizer with combinational edge and registered rise/fall.
// Revision : 1.0
// ============================================================================
module sync_edge_det (
   input  wire  clk,
   input  wire  rst,
   input  wire  async_in,
   output logic edge_det,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s3   <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1   <= async_in;
         s2   <= s1;
         s3   <= s2;
         rise <= s2 & ~s3;
         fall <= ~s2 & s3;
      end
   end

   assign edge_det = s2 ^ s3;

endmodule
`default_nettype wire

// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : clk_period_meter
// Brief    : Recovers the half-period of a slow toggling signal in clk_in cycles.
// Revision : 1.0
// ============================================================================
module clk_period_meter
   import clk_period_meter_pkg::*;
#(
   parameter int               WIDTH   = DEF_WIDTH,
   parameter logic [WIDTH-1:0] TIMEOUT = DEF_TIMEOUT
) (
   input  wire                 clk_in,
   input  wire                 rst,
   clk_period_meter_if.master  bus
);

   logic             edge_det;
   logic             rise;
   logic             fall;
   logic [WIDTH-1:0] cnt;
   state_t           state;
   state_t           state_nxt;
   logic             capture;
   logic             expire;

   sync_edge_det u_sync (
      .clk      (clk_in),
      .rst      (rst),
      .async_in (bus.sig_in),
      .edge_det (edge_det),
      .rise     (rise),
      .fall     (fall)
   );

   assign bus.rise_pulse = rise;
   assign bus.fall_pulse = fall;

   // Edge-to-edge spacing k leaves cnt at k-1 on the clock of the next edge.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (edge_det) begin
         cnt <= '0;
      end else if (cnt != TIMEOUT) begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // An edge always takes priority over the timeout on the same clock.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      expire    = 1'b0;
      case (state)
         IDLE: begin
            if (edge_det) begin
               state_nxt = ARMED;
            end
         end
         ARMED, TRACK: begin
            if (edge_det) begin
               capture   = 1'b1;
               state_nxt = TRACK;
            end else if (cnt == TIMEOUT) begin
               expire    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         bus.half_period <= '0;
         bus.meas_valid  <= 1'b0;
         bus.meas_stb    <= 1'b0;
         bus.locked      <= 1'b0;
         bus.timeout     <= 1'b0;
      end else begin
         bus.meas_stb <= capture;
         if (capture) begin
            bus.half_period <= cnt;
            bus.meas_valid  <= 1'b1;
            bus.locked      <= (state == TRACK) && (cnt == bus.half_period);
         end
         if (expire) begin
            bus.meas_valid <= 1'b0;
            bus.locked     <= 1'b0;
            bus.timeout    <= 1'b1;
         end
         if ((state == IDLE) && edge_det) begin
            bus.timeout <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_period_meter
// Brief    : Directed self-checking bench for clk_period_meter (TIMEOUT = 100).
// Revision : 1.0
// ============================================================================
module tb_clk_period_meter;
   import clk_period_meter_pkg::*;

   localparam int               WIDTH   = 26;
   localparam logic [WIDTH-1:0] TIMEOUT = 26'd100;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   clk_period_meter_if #(.WIDTH(WIDTH)) bus ();

   clk_period_meter #(
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_in (clk),
      .rst    (rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // A toggle driven at a negedge is visible on the outputs three negedges later.
   task automatic toggle();
      bus.sig_in = ~bus.sig_in;
   endtask

   task automatic check_meas(input string tag, input logic stb, input logic valid,
                             input logic [31:0] hp, input logic lck, input logic tmo);
      check_val({tag, ".stb"},   bus.meas_stb,    stb);
      check_val({tag, ".valid"}, bus.meas_valid,  valid);
      check_val({tag, ".hp"},    bus.half_period, hp);
      check_val({tag, ".lock"},  bus.locked,      lck);
      check_val({tag, ".tmo"},   bus.timeout,     tmo);
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst        = 1'b0;
      bus.sig_in = 1'b0;
      wait_cyc(3);
      check_meas("reset", 0, 0, 0, 0, 0);
      check_val("reset.rise", bus.rise_pulse, 0);
      check_val("reset.fall", bus.fall_pulse, 0);
      rst = 1'b1;
      wait_cyc(2);

      // Divider T=4: toggles 5 cycles apart
      toggle(); wait_cyc(3);
      check_val("e1.rise", bus.rise_pulse, 1);
      check_meas("e1", 0, 0, 0, 0, 0);
      wait_cyc(2);
      toggle(); wait_cyc(3);
      check_val("e2.fall", bus.fall_pulse, 1);
      check_val("e2.rise", bus.rise_pulse, 0);
      check_meas("e2", 1, 1, 4, 0, 0);
      wait_cyc(1);
      check_val("e2.stb_once", bus.meas_stb, 0);
      check_val("e2.fall_once", bus.fall_pulse, 0);
      wait_cyc(1);
      toggle(); wait_cyc(3);
      check_val("e3.rise", bus.rise_pulse, 1);
      check_meas("e3", 1, 1, 4, 1, 0);

      // Spacing 5 -> 9
      wait_cyc(6);
      toggle(); wait_cyc(3);
      check_meas("e4", 1, 1, 8, 0, 0);
      wait_cyc(6);
      toggle(); wait_cyc(3);
      check_meas("e5", 1, 1, 8, 1, 0);

      // Timeout: cnt hits TIMEOUT on the 101st clock after the last edge
      wait_cyc(100);
      check_meas("pre_tmo", 0, 1, 8, 1, 0);
      wait_cyc(1);
      check_meas("tmo", 0, 0, 8, 0, 1);
      toggle(); wait_cyc(3);
      check_meas("rearm", 0, 0, 8, 0, 0);

      // Edge lands on the clock where cnt == TIMEOUT: edge wins (ARMED, then TRACK)
      wait_cyc(98);
      toggle(); wait_cyc(3);
      check_meas("coinc_armed", 1, 1, 100, 0, 0);
      wait_cyc(98);
      toggle(); wait_cyc(3);
      check_meas("coinc_track", 1, 1, 100, 1, 0);

      // Asynchronous reset between clock edges while tracking
      wait_cyc(2);
      #2 rst = 1'b0;
      #1;
      check_meas("async_rst", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      wait_cyc(1);
      toggle(); wait_cyc(3);
      check_val("post_rst.rise", bus.rise_pulse, 1);
      check_meas("post_rst1", 0, 0, 0, 0, 0);
      wait_cyc(2);
      toggle(); wait_cyc(3);
      check_meas("post_rst2", 1, 1, 4, 0, 0);

      // Toggle every cycle: edge i becomes visible one negedge after toggle i+2
      wait_cyc(2);
      for (int j = 0; j < 10; j++) begin
         toggle();
         @(negedge clk);
         if (j >= 3) begin
            check_val("fast.stb",  bus.meas_stb,    1);
            check_val("fast.hp",   bus.half_period, 0);
            check_val("fast.rise", bus.rise_pulse,  ((j - 2) % 2 == 0) ? 1 : 0);
            check_val("fast.fall", bus.fall_pulse,  ((j - 2) % 2 == 1) ? 1 : 0);
            check_val("fast.lock", bus.locked,      (j - 2 >= 2) ? 1 : 0);
         end
      end
      wait_cyc(4);
      check_val("fast_end.stb", bus.meas_stb, 0);
      check_val("fast_end.valid", bus.meas_valid, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
